// File: rtl/lsu_req.sv
// EX->MEM load/store request unit: opcode decode, SRAM-like req/addr_ok/data_ok handshake, flush drain.
// Request is issued combinationally in IDLE; pipeline stalls until data returns (best case 2 cycles).
module lsu_req #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [11:0] ex_memop_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        ex_stall_i,
  input  logic        ex_flush_i,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_wstrb_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] mem_memdata_o,
  output logic [1:0]  mem_memaddr_low_o,
  output logic        mem_adel_o,
  output logic        mem_ades_o,
  output logic        lsu_stallreq_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      r_state;

  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;

  logic [31:0] r_memdata;
  logic [1:0]  r_memaddr_low;
  logic        r_adel;
  logic        r_ades;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_memop_vld;
  logic        w_misal;
  logic        w_issue;
  logic        w_stall;
  logic        w_adv;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  assign w_is_load   = |(ex_memop_i & 12'h31F);
  assign w_is_store  = |(ex_memop_i & 12'hCE0);
  assign w_memop_vld = ex_valid_i & (|ex_memop_i);

  // Unaligned lwl/lwr/swl/swr are legal by construction and never flagged.
  assign w_misal = ALIGN_CHECK &
                   (((ex_memop_i[2] | ex_memop_i[3] | ex_memop_i[6]) & ex_addr_i[0]) |
                    ((ex_memop_i[4] | ex_memop_i[7]) & (|ex_addr_i[1:0])));

  assign w_issue = ~rst & w_memop_vld & ~w_misal & ~ex_flush_i & (r_state == S_IDLE);

  assign w_stall = w_issue | (r_state == S_REQ) | (r_state == S_WAIT) | (r_state == S_DRAIN);
  assign w_adv   = ~ex_stall_i & ~w_stall;

  always_comb begin
    w_size  = 2'd2;
    w_addr  = {ex_addr_i[31:2], 2'b00};
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    if (ex_memop_i[0] | ex_memop_i[1] | ex_memop_i[5]) begin
      w_size = 2'd0;
      w_addr = ex_addr_i;
    end else if (ex_memop_i[2] | ex_memop_i[3] | ex_memop_i[6]) begin
      w_size = 2'd1;
      w_addr = ex_addr_i;
    end
    if (ex_memop_i[5]) begin
      w_wstrb = 4'b0001 << ex_addr_i[1:0];
      w_wdata = {4{ex_wdata_i[7:0]}};
    end else if (ex_memop_i[6]) begin
      w_wstrb = ex_addr_i[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{ex_wdata_i[15:0]}};
    end else if (ex_memop_i[7]) begin
      w_wstrb = 4'b1111;
      w_wdata = ex_wdata_i;
    end else if (ex_memop_i[10]) begin
      case (ex_addr_i[1:0])
        2'b00:   begin w_wstrb = 4'b0001; w_wdata = {24'h0, ex_wdata_i[31:24]}; end
        2'b01:   begin w_wstrb = 4'b0011; w_wdata = {16'h0, ex_wdata_i[31:16]}; end
        2'b10:   begin w_wstrb = 4'b0111; w_wdata = {8'h0, ex_wdata_i[31:8]}; end
        default: begin w_wstrb = 4'b1111; w_wdata = ex_wdata_i; end
      endcase
    end else if (ex_memop_i[11]) begin
      case (ex_addr_i[1:0])
        2'b00:   begin w_wstrb = 4'b1111; w_wdata = ex_wdata_i; end
        2'b01:   begin w_wstrb = 4'b1110; w_wdata = {ex_wdata_i[23:0], 8'h0}; end
        2'b10:   begin w_wstrb = 4'b1100; w_wdata = {ex_wdata_i[15:0], 16'h0}; end
        default: begin w_wstrb = 4'b1000; w_wdata = {ex_wdata_i[7:0], 24'h0}; end
      endcase
    end
  end

  // While waiting for addr_ok the request must not follow EX, so it replays the issue snapshot.
  always_comb begin
    data_req_o   = 1'b0;
    data_wr_o    = 1'b0;
    data_size_o  = 2'd0;
    data_addr_o  = 32'h0;
    data_wstrb_o = 4'b0000;
    data_wdata_o = 32'h0;
    if (r_state == S_REQ) begin
      data_req_o   = 1'b1;
      data_wr_o    = r_wr;
      data_size_o  = r_size;
      data_addr_o  = r_addr;
      data_wstrb_o = r_wstrb;
      data_wdata_o = r_wdata;
    end else if (w_issue) begin
      data_req_o   = 1'b1;
      data_wr_o    = w_is_store;
      data_size_o  = w_size;
      data_addr_o  = w_addr;
      data_wstrb_o = w_wstrb;
      data_wdata_o = w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wr          <= 1'b0;
      r_size        <= 2'd0;
      r_addr        <= 32'h0;
      r_wstrb       <= 4'b0000;
      r_wdata       <= 32'h0;
      r_memdata     <= 32'h0;
      r_memaddr_low <= 2'b00;
      r_adel        <= 1'b0;
      r_ades        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_wr    <= w_is_store;
            r_size  <= w_size;
            r_addr  <= w_addr;
            r_wstrb <= w_wstrb;
            r_wdata <= w_wdata;
            r_state <= data_addr_ok_i ? S_WAIT : S_REQ;
          end
        end
        S_REQ: begin
          if (ex_flush_i) begin
            r_state <= data_addr_ok_i ? S_DRAIN : S_IDLE;
          end else if (data_addr_ok_i) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_data_ok_i) begin
            if (ex_flush_i) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DONE;
              r_memdata <= data_rdata_i;
            end
          end else if (ex_flush_i) begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (~ex_stall_i | ex_flush_i) begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (data_data_ok_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_adv) begin
        if (ex_flush_i | ~w_memop_vld) begin
          r_memaddr_low <= 2'b00;
          r_adel        <= 1'b0;
          r_ades        <= 1'b0;
        end else begin
          r_memaddr_low <= ex_addr_i[1:0];
          r_adel        <= w_misal & w_is_load;
          r_ades        <= w_misal & w_is_store;
        end
      end
    end
  end

  assign mem_memdata_o     = r_memdata;
  assign mem_memaddr_low_o = r_memaddr_low;
  assign mem_adel_o        = r_adel;
  assign mem_ades_o        = r_ades;
  assign lsu_stallreq_o    = w_stall;

endmodule

// File: tb/tb_lsu_req.sv
// Scoreboard bench for lsu_req: expected requests and MEM-stage results are queued at issue and
// popped by a negedge monitor when the DUT presents a request or the EX/MEM register advances.
module tb_lsu_req;

  localparam logic [11:0] OP_LH  = 12'h004;
  localparam logic [11:0] OP_LW  = 12'h010;
  localparam logic [11:0] OP_SB  = 12'h020;
  localparam logic [11:0] OP_SH  = 12'h040;
  localparam logic [11:0] OP_SW  = 12'h080;
  localparam logic [11:0] OP_SWL = 12'h400;
  localparam logic [11:0] OP_SWR = 12'h800;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [11:0] ex_memop_i;
  logic [31:0] ex_addr_i;
  logic [31:0] ex_wdata_i;
  logic        ex_stall_i;
  logic        ex_flush_i;
  logic        data_req_o;
  logic        data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;
  logic [31:0] data_rdata_i;
  logic [31:0] mem_memdata_o;
  logic [1:0]  mem_memaddr_low_o;
  logic        mem_adel_o;
  logic        mem_ades_o;
  logic        lsu_stallreq_o;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [1:0]  low;
    logic        adel;
    logic        ades;
    logic        chk_data;
    logic [31:0] data;
  } mem_t;

  req_t req_q[$];
  mem_t mem_q[$];

  int   n_chk = 0;
  int   n_err = 0;
  int   cnt_stall = 0;
  logic chk_mem = 1'b0;
  logic mem_pend = 1'b0;

  always #5 clk = ~clk;

  lsu_req #(.ALIGN_CHECK(1'b1)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_valid_i        (ex_valid_i),
    .ex_memop_i        (ex_memop_i),
    .ex_addr_i         (ex_addr_i),
    .ex_wdata_i        (ex_wdata_i),
    .ex_stall_i        (ex_stall_i),
    .ex_flush_i        (ex_flush_i),
    .data_req_o        (data_req_o),
    .data_wr_o         (data_wr_o),
    .data_size_o       (data_size_o),
    .data_addr_o       (data_addr_o),
    .data_wstrb_o      (data_wstrb_o),
    .data_wdata_o      (data_wdata_o),
    .data_addr_ok_i    (data_addr_ok_i),
    .data_data_ok_i    (data_data_ok_i),
    .data_rdata_i      (data_rdata_i),
    .mem_memdata_o     (mem_memdata_o),
    .mem_memaddr_low_o (mem_memaddr_low_o),
    .mem_adel_o        (mem_adel_o),
    .mem_ades_o        (mem_ades_o),
    .lsu_stallreq_o    (lsu_stallreq_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: request beats and MEM-stage results, sampled mid-cycle.
  always @(negedge clk) begin
    req_t e;
    mem_t m;
    if (!rst) begin
      if (lsu_stallreq_o) cnt_stall++;
      if (data_req_o) begin
        if (req_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL req_unexpected: request addr 0x%08h with none expected", data_addr_o);
        end else begin
          e = req_q[0];
          chk("req_wr",    32'(data_wr_o),    32'(e.wr));
          chk("req_size",  32'(data_size_o),  32'(e.size));
          chk("req_addr",  data_addr_o,       e.addr);
          chk("req_wstrb", 32'(data_wstrb_o), 32'(e.wstrb));
          chk("req_wdata", data_wdata_o,      e.wdata);
          if (data_addr_ok_i) void'(req_q.pop_front());
        end
      end
      if (mem_pend) begin
        mem_pend = 1'b0;
        if (mem_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL mem_unexpected: advance with no expected MEM entry");
        end else begin
          m = mem_q.pop_front();
          chk("mem_addr_low", 32'(mem_memaddr_low_o), 32'(m.low));
          chk("mem_adel",     32'(mem_adel_o),        32'(m.adel));
          chk("mem_ades",     32'(mem_ades_o),        32'(m.ades));
          if (m.chk_data) chk("mem_memdata", mem_memdata_o, m.data);
        end
      end
      if (chk_mem && !ex_stall_i && !lsu_stallreq_o) mem_pend = 1'b1;
    end
  end

  task automatic set_ex(input logic v, input logic [11:0] op, input logic [31:0] a, input logic [31:0] d);
    ex_valid_i = v;
    ex_memop_i = op;
    ex_addr_i  = a;
    ex_wdata_i = d;
  endtask

  // One full transaction: aok_w cycles without addr_ok, dok_w cycles without data_ok.
  task automatic do_op(input string name, input logic [11:0] op, input logic [31:0] a, input logic [31:0] d,
                       input int aok_w, input int dok_w, input logic [31:0] rdata,
                       input req_t er, input mem_t em, input int exp_stall, input logic perturb);
    int s0;
    s0 = cnt_stall;
    req_q.push_back(er);
    mem_q.push_back(em);
    set_ex(1'b1, op, a, d);
    chk_mem = 1'b1;
    for (int k = 0; k < aok_w; k++) begin
      if (perturb && k >= 1) begin
        ex_wdata_i = ~d;
        ex_addr_i  = a ^ 32'h0000_00F0;
      end
      data_addr_ok_i = 1'b0;
      step();
    end
    ex_wdata_i     = d;
    ex_addr_i      = a;
    data_addr_ok_i = 1'b1;
    step();
    data_addr_ok_i = 1'b0;
    for (int k = 0; k < dok_w; k++) step();
    data_data_ok_i = 1'b1;
    data_rdata_i   = rdata;
    step();
    data_data_ok_i = 1'b0;
    data_rdata_i   = 32'h0;
    step();
    set_ex(1'b0, 12'h0, 32'h0, 32'h0);
    chk_mem = 1'b0;
    step();
    chk({name, "_stall_cycles"}, 32'(cnt_stall - s0), 32'(exp_stall));
  endtask

  task automatic misal(input string name, input logic [11:0] op, input logic [31:0] a, input mem_t em);
    mem_q.push_back(em);
    set_ex(1'b1, op, a, 32'h0);
    chk_mem = 1'b1;
    @(negedge clk);
    chk({name, "_req"},   32'(data_req_o),     32'd0);
    chk({name, "_stall"}, 32'(lsu_stallreq_o), 32'd0);
    step();
    set_ex(1'b0, 12'h0, 32'h0, 32'h0);
    chk_mem = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    set_ex(1'b0, 12'h0, 32'h0, 32'h0);
    ex_stall_i     = 1'b0;
    ex_flush_i     = 1'b0;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'hFFFF_FFFF;
    repeat (2) step();

    @(negedge clk);
    chk("rst_req",      32'(data_req_o),        32'd0);
    chk("rst_wr",       32'(data_wr_o),         32'd0);
    chk("rst_size",     32'(data_size_o),       32'd0);
    chk("rst_addr",     data_addr_o,            32'd0);
    chk("rst_wstrb",    32'(data_wstrb_o),      32'd0);
    chk("rst_wdata",    data_wdata_o,           32'd0);
    chk("rst_memdata",  mem_memdata_o,          32'd0);
    chk("rst_addr_low", 32'(mem_memaddr_low_o), 32'd0);
    chk("rst_adel",     32'(mem_adel_o),        32'd0);
    chk("rst_ades",     32'(mem_ades_o),        32'd0);
    chk("rst_stall",    32'(lsu_stallreq_o),    32'd0);
    step();
    rst = 1'b0;
    step();
    data_data_ok_i = 1'b0;
    data_rdata_i   = 32'h0;
    @(negedge clk);
    chk("stray_dok_after_rst", mem_memdata_o, 32'd0);
    step();

    do_op("lw_best", OP_LW, 32'h8000_0004, 32'h0, 0, 0, 32'h1234_5678,
          '{1'b0, 2'd2, 32'h8000_0004, 4'b0000, 32'h0},
          '{2'b00, 1'b0, 1'b0, 1'b1, 32'h1234_5678}, 2, 1'b0);

    do_op("sb", OP_SB, 32'h1000_0002, 32'hAABB_CCDD, 0, 0, 32'h0,
          '{1'b1, 2'd0, 32'h1000_0002, 4'b0100, 32'hDDDD_DDDD},
          '{2'b10, 1'b0, 1'b0, 1'b0, 32'h0}, 2, 1'b0);
    do_op("sh", OP_SH, 32'h1000_0002, 32'hAABB_CCDD, 0, 0, 32'h0,
          '{1'b1, 2'd1, 32'h1000_0002, 4'b1100, 32'hCCDD_CCDD},
          '{2'b10, 1'b0, 1'b0, 1'b0, 32'h0}, 2, 1'b0);
    do_op("swl", OP_SWL, 32'h1000_0002, 32'hAABB_CCDD, 0, 0, 32'h0,
          '{1'b1, 2'd2, 32'h1000_0000, 4'b0111, 32'h00AA_BBCC},
          '{2'b10, 1'b0, 1'b0, 1'b0, 32'h0}, 2, 1'b0);
    do_op("swr", OP_SWR, 32'h1000_0002, 32'hAABB_CCDD, 0, 0, 32'h0,
          '{1'b1, 2'd2, 32'h1000_0000, 4'b1100, 32'hCCDD_0000},
          '{2'b10, 1'b0, 1'b0, 1'b0, 32'h0}, 2, 1'b0);

    misal("lw_misal", OP_LW, 32'h1000_0002, '{2'b10, 1'b1, 1'b0, 1'b0, 32'h0});
    misal("sh_misal", OP_SH, 32'h1000_0001, '{2'b01, 1'b0, 1'b1, 1'b0, 32'h0});

    do_op("sw_aok3", OP_SW, 32'h2000_0008, 32'h1122_3344, 3, 0, 32'h0,
          '{1'b1, 2'd2, 32'h2000_0008, 4'b1111, 32'h1122_3344},
          '{2'b00, 1'b0, 1'b0, 1'b0, 32'h0}, 5, 1'b1);
    do_op("lh", OP_LH, 32'h5000_0006, 32'h0, 0, 0, 32'h0000_BEEF,
          '{1'b0, 2'd1, 32'h5000_0006, 4'b0000, 32'h0},
          '{2'b10, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF}, 2, 1'b0);
    do_op("lw_dok2", OP_LW, 32'h3000_000C, 32'h0, 0, 2, 32'hCAFE_F00D,
          '{1'b0, 2'd2, 32'h3000_000C, 4'b0000, 32'h0},
          '{2'b00, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D}, 4, 1'b0);

    // Flush while waiting for data: drain, no new request, buffer untouched.
    req_q.push_back('{1'b0, 2'd2, 32'h6000_0000, 4'b0000, 32'h0});
    set_ex(1'b1, OP_LW, 32'h6000_0000, 32'h0);
    data_addr_ok_i = 1'b1;
    @(negedge clk);
    chk("fw_c0_stall", 32'(lsu_stallreq_o), 32'd1);
    step();
    data_addr_ok_i = 1'b0;
    ex_flush_i     = 1'b1;
    @(negedge clk);
    chk("fw_wait_stall", 32'(lsu_stallreq_o), 32'd1);
    step();
    ex_flush_i = 1'b0;
    set_ex(1'b1, OP_LW, 32'h6000_0010, 32'h0);
    @(negedge clk);
    chk("fw_drain_stall", 32'(lsu_stallreq_o), 32'd1);
    chk("fw_drain_noreq", 32'(data_req_o),     32'd0);
    step();
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("fw_dok_stall", 32'(lsu_stallreq_o), 32'd1);
    chk("fw_dok_noreq", 32'(data_req_o),     32'd0);
    step();
    data_data_ok_i = 1'b0;
    data_rdata_i   = 32'h0;
    set_ex(1'b0, 12'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("fw_idle_stall",   32'(lsu_stallreq_o), 32'd0);
    chk("fw_memdata_hold", mem_memdata_o,       32'hCAFE_F00D);
    step();

    // Flush while the request is still unaccepted: request withdrawn.
    req_q.push_back('{1'b1, 2'd0, 32'h4000_0003, 4'b1000, 32'h5555_5555});
    set_ex(1'b1, OP_SB, 32'h4000_0003, 32'h0000_0055);
    @(negedge clk);
    chk("fr_c0_stall", 32'(lsu_stallreq_o), 32'd1);
    step();
    ex_flush_i = 1'b1;
    @(negedge clk);
    chk("fr_req_stall", 32'(lsu_stallreq_o), 32'd1);
    step();
    ex_flush_i = 1'b0;
    set_ex(1'b0, 12'h0, 32'h0, 32'h0);
    void'(req_q.pop_front());
    @(negedge clk);
    chk("fr_req_dropped", 32'(data_req_o),     32'd0);
    chk("fr_stall_clear", 32'(lsu_stallreq_o), 32'd0);
    step();
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h7777_7777;
    step();
    data_data_ok_i = 1'b0;
    data_rdata_i   = 32'h0;
    @(negedge clk);
    chk("idle_dok_ignored", mem_memdata_o, 32'hCAFE_F00D);
    step();

    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
